// File: rtl/noc_ni_param.sv
// noc_ni_param: network interface between a processor word port and a NoC flit link.
//
// TX: one DATA_W word becomes a header flit plus L body flits, where L counts the body
//     slices up to and including the highest non-zero FLIT_W slice (minimum 1). The header
//     is {HDR_TAG, L-1, dest}. tx_last marks the final body flit only.
// RX: headers are checked for tag and destination. Body flits are assembled LSB slice first
//     into a zero-filled word, and the word is queued in an RX_DEPTH-entry FIFO.
//     Protocol errors pulse rx_err and bump a saturating 8-bit counter.
//
// Ports:
//   clk, rst                             clock, asynchronous active-high reset
//   proc_data/proc_dest/proc_valid/proc_ready   processor TX word handshake
//   tx_flit/tx_valid/tx_last/tx_ready           outgoing flit link (registered)
//   rx_flit/rx_valid/rx_last/rx_ready           incoming flit link
//   out_data/out_valid/out_ready                received-word FIFO head (registered)
//   rx_err, rx_err_cnt                          error pulse and saturating count
module noc_ni_param #(
    parameter int FLIT_W = 8,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2,
    parameter int LEN_W  = ((DATA_W / FLIT_W) > 1) ? $clog2(DATA_W / FLIT_W) : 1,
    parameter logic [FLIT_W-LEN_W-ADDR_W-1:0] HDR_TAG = 4'b1011,
    parameter logic [ADDR_W-1:0] NODE_ADDR = 2'd0,
    parameter int RX_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] proc_data,
    input  logic [ADDR_W-1:0] proc_dest,
    input  logic              proc_valid,
    output logic              proc_ready,
    output logic [FLIT_W-1:0] tx_flit,
    output logic              tx_valid,
    output logic              tx_last,
    input  logic              tx_ready,
    input  logic [FLIT_W-1:0] rx_flit,
    input  logic              rx_valid,
    input  logic              rx_last,
    output logic              rx_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              rx_err,
    output logic [7:0]        rx_err_cnt
);
    localparam int NF    = DATA_W / FLIT_W;
    localparam int TAG_W = FLIT_W - LEN_W - ADDR_W;
    localparam int PTR_W = $clog2(RX_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_HEAD = 2'd1, TX_BODY = 2'd2} tx_state_t;
    typedef enum logic [1:0] {RX_HEAD = 2'd0, RX_BODY = 2'd1, RX_DROP = 2'd2} rx_state_t;

    // Index of the highest non-zero slice (0 for an all-zero word), i.e. L-1.
    function automatic logic [LEN_W-1:0] last_slice_idx(input logic [DATA_W-1:0] d);
        logic [LEN_W-1:0] r;
        r = {LEN_W{1'b0}};
        for (int i = 0; i < NF; i++) begin
            if (d[i*FLIT_W +: FLIT_W] != {FLIT_W{1'b0}}) begin
                r = LEN_W'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [FLIT_W-1:0] get_slice(input logic [DATA_W-1:0] d,
                                                    input logic [LEN_W-1:0]  idx);
        logic [FLIT_W-1:0] r;
        r = {FLIT_W{1'b0}};
        for (int i = 0; i < NF; i++) begin
            if (LEN_W'(i) == idx) begin
                r = d[i*FLIT_W +: FLIT_W];
            end
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] put_slice(input logic [DATA_W-1:0] d,
                                                    input logic [LEN_W-1:0]  idx,
                                                    input logic [FLIT_W-1:0] f);
        logic [DATA_W-1:0] r;
        r = d;
        for (int i = 0; i < NF; i++) begin
            if (LEN_W'(i) == idx) begin
                r[i*FLIT_W +: FLIT_W] = f;
            end
        end
        return r;
    endfunction

    // ---------------------------------------------------------------- TX path
    tx_state_t         tx_state_r, tx_state_s;
    logic [DATA_W-1:0] tx_data_r, tx_data_s;
    logic [LEN_W-1:0]  tx_len_r, tx_len_s;
    logic [LEN_W-1:0]  tx_idx_r, tx_idx_s;
    logic [FLIT_W-1:0] tx_flit_s;
    logic              tx_valid_s, tx_last_s, proc_ready_s;

    // TX next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        tx_state_s   = tx_state_r;
        tx_data_s    = tx_data_r;
        tx_len_s     = tx_len_r;
        tx_idx_s     = tx_idx_r;
        tx_flit_s    = tx_flit;
        tx_valid_s   = tx_valid;
        tx_last_s    = tx_last;
        proc_ready_s = proc_ready;
        case (tx_state_r)
            TX_IDLE: begin
                if (proc_valid && proc_ready) begin
                    tx_data_s    = proc_data;
                    tx_len_s     = last_slice_idx(proc_data);
                    tx_flit_s    = {HDR_TAG, last_slice_idx(proc_data), proc_dest};
                    tx_valid_s   = 1'b1;
                    tx_last_s    = 1'b0;
                    proc_ready_s = 1'b0;
                    tx_state_s   = TX_HEAD;
                end else begin
                    tx_state_s = TX_IDLE;
                end
            end
            TX_HEAD: begin
                if (tx_valid && tx_ready) begin
                    tx_idx_s   = {LEN_W{1'b0}};
                    tx_flit_s  = get_slice(tx_data_r, {LEN_W{1'b0}});
                    tx_last_s  = (tx_len_r == {LEN_W{1'b0}});
                    tx_state_s = TX_BODY;
                end else begin
                    tx_state_s = TX_HEAD;
                end
            end
            TX_BODY: begin
                if (tx_valid && tx_ready) begin
                    if (tx_idx_r == tx_len_r) begin
                        tx_flit_s    = {FLIT_W{1'b0}};
                        tx_valid_s   = 1'b0;
                        tx_last_s    = 1'b0;
                        proc_ready_s = 1'b1;
                        tx_state_s   = TX_IDLE;
                    end else begin
                        tx_idx_s  = tx_idx_r + LEN_W'(1);
                        tx_flit_s = get_slice(tx_data_r, tx_idx_s);
                        tx_last_s = (tx_idx_s == tx_len_r);
                    end
                end else begin
                    tx_state_s = TX_BODY;
                end
            end
            default: begin
                tx_flit_s    = {FLIT_W{1'b0}};
                tx_valid_s   = 1'b0;
                tx_last_s    = 1'b0;
                proc_ready_s = 1'b1;
                tx_state_s   = TX_IDLE;
            end
        endcase
    end

    // TX state and registered link outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_r <= TX_IDLE;
            tx_data_r  <= {DATA_W{1'b0}};
            tx_len_r   <= {LEN_W{1'b0}};
            tx_idx_r   <= {LEN_W{1'b0}};
            tx_flit    <= {FLIT_W{1'b0}};
            tx_valid   <= 1'b0;
            tx_last    <= 1'b0;
            proc_ready <= 1'b1;
        end else begin
            tx_state_r <= tx_state_s;
            tx_data_r  <= tx_data_s;
            tx_len_r   <= tx_len_s;
            tx_idx_r   <= tx_idx_s;
            tx_flit    <= tx_flit_s;
            tx_valid   <= tx_valid_s;
            tx_last    <= tx_last_s;
            proc_ready <= proc_ready_s;
        end
    end

    // ---------------------------------------------------------------- RX path
    rx_state_t         rx_state_r, rx_state_s;
    logic [LEN_W-1:0]  rx_len_r, rx_len_s;
    logic [LEN_W-1:0]  rx_idx_r, rx_idx_s;
    logic [DATA_W-1:0] rx_asm_r, rx_asm_s;
    logic              rx_accept_s, push_s, err_s;
    logic [DATA_W-1:0] push_word_s;

    // RX header check and body reassembly.
    always_comb begin
        rx_accept_s = rx_valid && rx_ready;
        rx_state_s  = rx_state_r;
        rx_len_s    = rx_len_r;
        rx_idx_s    = rx_idx_r;
        rx_asm_s    = rx_asm_r;
        push_s      = 1'b0;
        push_word_s = rx_asm_r;
        err_s       = 1'b0;
        case (rx_state_r)
            RX_HEAD: begin
                if (rx_accept_s) begin
                    if (rx_flit[FLIT_W-1 -: TAG_W] != HDR_TAG) begin
                        // A bad header flagged as last is a whole packet: nothing to drop.
                        err_s      = 1'b1;
                        rx_state_s = rx_last ? RX_HEAD : RX_DROP;
                    end else if (rx_last) begin
                        err_s      = 1'b1;
                        rx_state_s = RX_HEAD;
                    end else if (rx_flit[ADDR_W-1:0] != NODE_ADDR) begin
                        rx_state_s = RX_DROP;
                    end else begin
                        rx_len_s   = rx_flit[ADDR_W +: LEN_W];
                        rx_idx_s   = {LEN_W{1'b0}};
                        rx_asm_s   = {DATA_W{1'b0}};
                        rx_state_s = RX_BODY;
                    end
                end else begin
                    rx_state_s = RX_HEAD;
                end
            end
            RX_BODY: begin
                if (rx_accept_s) begin
                    rx_asm_s = put_slice(rx_asm_r, rx_idx_r, rx_flit);
                    if (rx_last && (rx_idx_r == rx_len_r)) begin
                        push_s      = 1'b1;
                        push_word_s = rx_asm_s;
                        rx_state_s  = RX_HEAD;
                    end else if (rx_last) begin
                        err_s      = 1'b1;
                        rx_state_s = RX_HEAD;
                    end else if (rx_idx_r == rx_len_r) begin
                        err_s      = 1'b1;
                        rx_state_s = RX_DROP;
                    end else begin
                        rx_idx_s = rx_idx_r + LEN_W'(1);
                    end
                end else begin
                    rx_state_s = RX_BODY;
                end
            end
            RX_DROP: begin
                if (rx_accept_s && rx_last) begin
                    rx_state_s = RX_HEAD;
                end else begin
                    rx_state_s = RX_DROP;
                end
            end
            default: begin
                rx_state_s = RX_HEAD;
            end
        endcase
    end

    // ---------------------------------------------------------------- RX FIFO
    logic [DATA_W-1:0] mem_r [RX_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
    logic [CNT_W-1:0]  count_r, count_s, remain_s;
    logic              pop_s;
    logic [DATA_W-1:0] head_s;
    logic              rx_ready_s;

    // FIFO pointer/count update and the next registered head word.
    always_comb begin
        pop_s    = out_valid && out_ready;
        rd_ptr_s = rd_ptr_r + PTR_W'(pop_s);
        wr_ptr_s = wr_ptr_r + PTR_W'(push_s);
        remain_s = count_r - CNT_W'(pop_s);
        count_s  = remain_s + CNT_W'(push_s);
        // An entry pushed this cycle is not in mem_r yet, so it bypasses when it becomes head.
        if (remain_s != {CNT_W{1'b0}}) begin
            head_s = mem_r[rd_ptr_s];
        end else if (push_s) begin
            head_s = push_word_s;
        end else begin
            head_s = {DATA_W{1'b0}};
        end
        if (rx_state_s == RX_DROP) begin
            rx_ready_s = 1'b1;
        end else begin
            rx_ready_s = (count_s != CNT_W'(RX_DEPTH));
        end
    end

    // RX state, FIFO storage and registered processor-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_r <= RX_HEAD;
            rx_len_r   <= {LEN_W{1'b0}};
            rx_idx_r   <= {LEN_W{1'b0}};
            rx_asm_r   <= {DATA_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            for (int i = 0; i < RX_DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            out_data   <= {DATA_W{1'b0}};
            out_valid  <= 1'b0;
            rx_ready   <= 1'b1;
        end else begin
            rx_state_r <= rx_state_s;
            rx_len_r   <= rx_len_s;
            rx_idx_r   <= rx_idx_s;
            rx_asm_r   <= rx_asm_s;
            wr_ptr_r   <= wr_ptr_s;
            rd_ptr_r   <= rd_ptr_s;
            count_r    <= count_s;
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_word_s;
            end
            out_data   <= head_s;
            out_valid  <= (count_s != {CNT_W{1'b0}});
            rx_ready   <= rx_ready_s;
        end
    end

    // Error pulse and saturating error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_err     <= 1'b0;
            rx_err_cnt <= 8'd0;
        end else begin
            rx_err <= err_s;
            if (err_s && (rx_err_cnt != 8'hFF)) begin
                rx_err_cnt <= rx_err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_noc_ni_param.sv
// Directed, table-driven bench for noc_ni_param (NODE_ADDR = 1).
module tb_noc_ni_param;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] proc_data;
    logic [1:0]  proc_dest;
    logic        proc_valid;
    logic        proc_ready;
    logic [7:0]  tx_flit;
    logic        tx_valid, tx_last, tx_ready;
    logic [7:0]  rx_flit;
    logic        rx_valid, rx_last, rx_ready;
    logic [31:0] out_data;
    logic        out_valid, out_ready;
    logic        rx_err;
    logic [7:0]  rx_err_cnt;

    int checks = 0;
    int errors = 0;
    int err_hi = 0;

    always #5 clk = ~clk;

    noc_ni_param #(.NODE_ADDR(2'd1)) dut (
        .clk(clk), .rst(rst),
        .proc_data(proc_data), .proc_dest(proc_dest), .proc_valid(proc_valid), .proc_ready(proc_ready),
        .tx_flit(tx_flit), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
        .rx_flit(rx_flit), .rx_valid(rx_valid), .rx_last(rx_last), .rx_ready(rx_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .rx_err(rx_err), .rx_err_cnt(rx_err_cnt)
    );

    always @(negedge clk) begin
        if (rx_err === 1'b1) err_hi = err_hi + 1;
    end

    typedef struct {
        logic [31:0]     data;
        logic [1:0]      dest;
        int              nfl;
        logic [4:0][7:0] fl;
        bit              toggle;
    } tx_vec_t;

    typedef struct {
        logic [7:0]  hdr;
        logic [31:0] word;
        int          nbody;
    } rx_vec_t;

    tx_vec_t    tv [6];
    rx_vec_t    rv [4];
    logic [7:0] cap_flit [8];
    logic       cap_last [8];
    int         cap_n;
    int         cap_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Sends one word; records accepted flits and the cycle at which proc_ready returns.
    task automatic tx_packet(input logic [31:0] d, input logic [1:0] dest, input bit toggle);
        logic [7:0] held_flit;
        logic       held_last;
        bit         stalled;
        held_flit = 8'h00;
        held_last = 1'b0;
        stalled = 0;
        cap_n = 0;
        cap_rdy = -1;
        chk("proc_ready_idle", {31'd0, proc_ready}, 32'd1);
        proc_data = d; proc_dest = dest; proc_valid = 1'b1; tx_ready = 1'b1;
        @(negedge clk);
        proc_valid = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (proc_ready && cap_n > 0) begin
                cap_rdy = cyc;
                break;
            end
            tx_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            if (stalled) begin
                chk("stall_flit", {24'd0, tx_flit}, {24'd0, held_flit});
                chk("stall_last", {31'd0, tx_last}, {31'd0, held_last});
                chk("stall_valid", {31'd0, tx_valid}, 32'd1);
            end
            if (tx_valid && tx_ready) begin
                if (cap_n < 8) begin
                    cap_flit[cap_n] = tx_flit;
                    cap_last[cap_n] = tx_last;
                end
                cap_n++;
                stalled = 0;
            end else if (tx_valid) begin
                stalled = 1;
                held_flit = tx_flit;
                held_last = tx_last;
            end else begin
                stalled = 0;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_tx_vec(input int k);
        tx_packet(tv[k].data, tv[k].dest, tv[k].toggle);
        chk($sformatf("tx%0d_nflits", k), cap_n, tv[k].nfl);
        for (int i = 0; i < tv[k].nfl && i < 8; i++) begin
            chk($sformatf("tx%0d_flit%0d", k, i), {24'd0, cap_flit[i]}, {24'd0, tv[k].fl[i]});
            chk($sformatf("tx%0d_last%0d", k, i), {31'd0, cap_last[i]}, (i == tv[k].nfl - 1) ? 32'd1 : 32'd0);
        end
        if (tv[k].toggle) chk($sformatf("tx%0d_ready_back", k), (cap_rdy > 0) ? 32'd1 : 32'd0, 32'd1);
        else              chk($sformatf("tx%0d_ready_cyc", k), cap_rdy, tv[k].nfl + 1);
    endtask

    task automatic rx_send(input logic [7:0] f, input logic l);
        int w;
        w = 0;
        while (!rx_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
        rx_flit = f; rx_last = l; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; rx_last = 1'b0;
    endtask

    task automatic rx_packet(input logic [7:0] hdr, input logic [31:0] word, input int nbody);
        logic [31:0] w;
        w = word;
        rx_send(hdr, 1'b0);
        for (int i = 0; i < nbody; i++) rx_send(w[i*8 +: 8], (i == nbody - 1));
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int e0;
        tv[0] = '{32'h12345678, 2'd1, 5, {8'h12, 8'h34, 8'h56, 8'h78, 8'hBD}, 1'b0};
        tv[1] = '{32'h00340012, 2'd1, 4, {8'h00, 8'h34, 8'h00, 8'h12, 8'hB9}, 1'b0};
        tv[2] = '{32'h00000000, 2'd2, 2, {8'h00, 8'h00, 8'h00, 8'h00, 8'hB2}, 1'b0};
        tv[3] = '{32'h00000100, 2'd3, 3, {8'h00, 8'h00, 8'h01, 8'h00, 8'hB7}, 1'b0};
        tv[4] = '{32'hFF000000, 2'd0, 5, {8'hFF, 8'h00, 8'h00, 8'h00, 8'hBC}, 1'b0};
        tv[5] = '{32'h12345678, 2'd1, 5, {8'h12, 8'h34, 8'h56, 8'h78, 8'hBD}, 1'b1};
        rv[0] = '{8'hBD, 32'h11223344, 4};
        rv[1] = '{8'hB1, 32'h000000A5, 1};
        rv[2] = '{8'hB5, 32'h0000BEEF, 2};
        rv[3] = '{8'hBD, 32'hCAFE0001, 4};

        rst = 1'b1;
        proc_data = 32'd0; proc_dest = 2'd0; proc_valid = 1'b0; tx_ready = 1'b0;
        rx_flit = 8'd0; rx_valid = 1'b0; rx_last = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_proc_ready", {31'd0, proc_ready}, 32'd1);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_last", {31'd0, tx_last}, 32'd0);
        chk("rst_tx_flit", {24'd0, tx_flit}, 32'd0);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_rx_err", {31'd0, rx_err}, 32'd0);
        chk("rst_err_cnt", {24'd0, rx_err_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 6; k++) run_tx_vec(k);

        // RX loopback of a suppressed-zero packet
        rx_packet(8'hB9, 32'h00340012, 3);
        chk("loop_valid", {31'd0, out_valid}, 32'd1);
        chk("loop_data", out_data, 32'h00340012);
        pop_one();
        chk("loop_empty", {31'd0, out_valid}, 32'd0);

        // fill the FIFO with the consumer stalled
        for (int k = 0; k < 4; k++) begin
            rx_packet(rv[k].hdr, rv[k].word, rv[k].nbody);
            chk($sformatf("fill%0d_valid", k), {31'd0, out_valid}, 32'd1);
        end
        chk("full_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("full_head", out_data, rv[0].word);
        pop_one();
        chk("pop_rx_ready", {31'd0, rx_ready}, 32'd1);
        for (int k = 1; k < 4; k++) begin
            chk($sformatf("drain%0d_valid", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("drain%0d_data", k), out_data, rv[k].word);
            pop_one();
        end
        chk("drain_empty", {31'd0, out_valid}, 32'd0);

        // protocol errors
        e0 = err_hi;
        rx_send(8'hA1, 1'b0); rx_send(8'h11, 1'b0); rx_send(8'h22, 1'b1);
        chk("bad_tag_cnt", {24'd0, rx_err_cnt}, 32'd1);
        rx_send(8'hBD, 1'b0); rx_send(8'h33, 1'b0); rx_send(8'h44, 1'b1);
        chk("early_last_cnt", {24'd0, rx_err_cnt}, 32'd2);
        rx_send(8'hB2, 1'b0); rx_send(8'h55, 1'b1);
        chk("other_dest_cnt", {24'd0, rx_err_cnt}, 32'd2);
        rx_send(8'hBD, 1'b1);
        chk("hdr_last_cnt", {24'd0, rx_err_cnt}, 32'd3);
        rx_send(8'hB1, 1'b0); rx_send(8'h55, 1'b0); rx_send(8'h66, 1'b1);
        chk("missing_last_cnt", {24'd0, rx_err_cnt}, 32'd4);
        chk("err_pulse_cycles", err_hi - e0, 32'd4);
        chk("err_no_word", {31'd0, out_valid}, 32'd0);
        rx_packet(8'hB1, 32'h00000077, 1);
        chk("after_err_data", out_data, 32'h00000077);
        pop_one();

        // saturate the error counter
        for (int i = 0; i < 260; i++) rx_send(8'h00, 1'b1);
        chk("err_cnt_sat", {24'd0, rx_err_cnt}, 32'd255);

        // reset while TX and RX are both mid-body
        tx_ready = 1'b1; proc_data = 32'h12345678; proc_dest = 2'd1; proc_valid = 1'b1;
        rx_flit = 8'hBD; rx_valid = 1'b1; rx_last = 1'b0;
        @(negedge clk);
        proc_valid = 1'b0; rx_flit = 8'h11;
        @(negedge clk);
        tx_ready = 1'b0; rx_valid = 1'b0;
        chk("pre_rst_body_flit", {24'd0, tx_flit}, 32'h78);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("mid_rst_proc_ready", {31'd0, proc_ready}, 32'd1);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_err_cnt", {24'd0, rx_err_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_tx_idle", {31'd0, tx_valid}, 32'd0);
            chk("post_rst_fifo_empty", {31'd0, out_valid}, 32'd0);
        end
        run_tx_vec(1);
        rx_packet(8'hB9, 32'h00340012, 3);
        chk("post_rst_rx_data", out_data, 32'h00340012);
        chk("post_rst_err_cnt", {24'd0, rx_err_cnt}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
